intr_ctrl: RTL and testbench
============================

# intr_ctrl

Parametrised interrupt controller that replaces the fixed two-source timer/external interrupt logic inside the MCU controller. It accepts N_SRC interrupt lines, each with per-source enable, edge or level mode and software trigger, and resolves them by fixed priority. It presents one vectored request to the core through a req/ack handshake and keeps a hardware stack of saved program counters so that higher-priority interrupts can nest. The core reaches the controller through a small register port, in the same way it reaches the timer.

## Interface
- N_SRC, 8: number of interrupt sources, 1..16; index 0 has the highest priority.
- PC_W, 8: program counter width.
- VEC_BASE, 16: vector of source 0.
- VEC_STRIDE, 16: vector spacing; vector(i) = (VEC_BASE + i*VEC_STRIDE) mod 2^PC_W.
- STACK_D, 4: depth of the saved-PC stack, 1..8.
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- irq_src  in  N_SRC  raw interrupt lines, asynchronous.
- reg_we  in  1  register write strobe.
- reg_addr  in  3  register select.
- reg_wdata  in  16  write data.
- reg_rdata  out  16  read data, registered, valid the cycle after reg_addr is presented.
- irq_req  out  1  vectored request to the core.
- irq_vec  out  PC_W  target PC; held stable while irq_req=1.
- irq_id  out  4  index of the winning source.
- irq_ack  in  1  core takes the interrupt at an instruction boundary.
- pc_in  in  PC_W  PC to save; sampled with irq_ack.
- reti  in  1  one-cycle return-from-interrupt pulse.
- ret_pc  out  PC_W  restored PC.
- ret_valid  out  1  one-cycle pulse; ret_pc is valid in the same cycle.

## Operation
- Registers (bits at or above N_SRC read 0 and ignore writes):
  - 0 CTRL: [15] global enable GE; [8] nest enable NE; [1] ERR, sticky, write 1 to clear; [0] OVF, sticky, write 1 to clear.
  - 1 ENABLE: per-source enable.
  - 2 PENDING: read gives pending bits; a write of 1 clears an edge-mode bit.
  - 3 MODE: 1 = edge, 0 = level.
  - 4 ACTIVE: read-only; bits set for sources in service.
  - 5 SAVED_PC: read-only; top of the stack, 0 when the stack is empty.
  - 6 FORCE: a write of 1 sets the pending bit; edge mode only.
  - 7 DEPTH: read-only; stack occupancy.
- Input path:
  - Each irq_src bit passes through a 2-flop synchroniser.
  - Edge mode: a synchronised 0->1 transition sets pending.
  - Level mode: pending equals the synchronised level. PENDING writes and FORCE have no effect on level-mode bits.
- Eligibility: a source is eligible when pending & ENABLE & GE.
  - ACTIVE empty: any eligible source may be requested.
  - ACTIVE non-empty with NE=1: only sources with a lower index than the lowest set ACTIVE bit may be requested.
  - ACTIVE non-empty with NE=0: no request.
  - No request while the stack is full.
- Selection: the lowest-index eligible source wins.
- State machine:
  - IDLE: irq_req=0. When a candidate exists, latch irq_id and irq_vec and go to REQ.
  - REQ: irq_req=1, with irq_vec and irq_id frozen. A higher-priority arrival does not retarget the request.
  - REQ -> IDLE on irq_ack. Actions on that edge:
    - push pc_in onto the stack;
    - set ACTIVE[id];
    - clear pending[id] if the source is edge mode.
  - REQ -> IDLE with no ack if the latched source stops being eligible (pending cleared, disabled, or GE=0). This is request withdrawal.
- reti with a non-empty stack:
  - pop the stack and drive the popped value on ret_pc with ret_valid;
  - clear the lowest set ACTIVE bit.
- Boundary cases:
  - reti with an empty stack: ignored; ERR is set.
  - irq_ack while irq_req=0: ignored; ERR is set.
  - irq_ack and reti in the same cycle: the ack is processed, reti is dropped, and ERR is set.
  - A candidate is blocked only by a full stack: OVF is set and the request is held off until a pop.
  - A PENDING write-1-clear coincides with a new edge on the same bit: the set wins.
  - ENABLE gating does not affect latching: pending still latches while a source is disabled.
- Reset: every register, the stack, state=IDLE, and all outputs (irq_req, irq_vec, irq_id, ret_pc, ret_valid, reg_rdata) go to 0. A reset mid-handshake discards the request and the stack.

## Timing
- Edge latency: irq_src rises at edge k. Synchroniser output goes high at k+2, pending at k+3, and irq_req at k+4.
- After REQ is entered, irq_req stays high until the edge where irq_ack=1 is sampled. It is low in the following cycle.
- The earliest possible new request is 1 cycle after the ack edge.
- reti sampled at edge r: ret_valid=1 and ret_pc are valid in cycle r+1, for exactly one cycle.
- Register writes take effect at the write edge. A read returns the value from after any write in the previous cycle.
- Level mode: deassertion is also seen 3 edges later. If the source is still asserted after reti, the request repeats.

## Test plan
- Edge latency and vector: setup GE=1, ENABLE=0x01, MODE=0x01. irq_src[0] rises at edge k.
  - Required: irq_req=1 at k+4 with irq_vec=16 and irq_id=0.
  - Then ack with pc_in=0x05. Required: DEPTH=1, SAVED_PC=0x05, ACTIVE=0x01, PENDING=0x00.
- Priority and non-retargeting: sources 3 and 5 pend together.
  - Required: irq_vec=64 (source 3).
  - Source 1 rises while in REQ. Required: irq_vec stays 64 until ack.
  - With NE=1: source 1 is requested next with vec=32.
- Nesting and return: ack 5, ack 3, ack 1 with pc_in 0x10, 0x40, 0x42.
  - Three reti pulses. Required: ret_pc 0x42, 0x40, 0x10 in that order, and ACTIVE clears bit 1, then 3, then 5.
- Overflow and errors:
  - STACK_D=2 with three nested sources. Required: the third request is held off and OVF=1.
  - reti with an empty stack. Required: ERR=1 and no ret_valid.
  - ack while idle. Required: ERR=1.
- Level mode and withdrawal:
  - Level source held high across reti. Required: it is re-requested 1 cycle after the pop.
  - ENABLE cleared during REQ. Required: irq_req drops in the next cycle and no push occurs.
- Reset mid-REQ with DEPTH=2. Required: all outputs and registers read 0 in the cycle after rst.

Source files
------------

// File: rtl/intr_ctrl.sv
// intr_ctrl: fixed-priority vectored interrupt controller with per-source edge/level
// inputs, a req/ack handshake to the core and a saved-PC stack for nesting.
module intr_ctrl #(
   parameter int N_SRC      = 8,
   parameter int PC_W       = 8,
   parameter int VEC_BASE   = 16,
   parameter int VEC_STRIDE = 16,
   parameter int STACK_D    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             reg_we,
   input  logic [2:0]       reg_addr,
   input  logic [15:0]      reg_wdata,
   output logic [15:0]      reg_rdata,
   output logic             irq_req,
   output logic [PC_W-1:0]  irq_vec,
   output logic [3:0]       irq_id,
   input  logic             irq_ack,
   input  logic [PC_W-1:0]  pc_in,
   input  logic             reti,
   output logic [PC_W-1:0]  ret_pc,
   output logic             ret_valid
);
   localparam int DW = $clog2(STACK_D + 1);

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t           r_state, w_state_next;
   logic [N_SRC-1:0] r_sync1, r_sync2, r_sync_d;
   logic [N_SRC-1:0] r_pend, r_en, r_mode, r_active;
   logic             r_ge, r_ne, r_err, r_ovf;
   logic [PC_W-1:0]  r_stack [STACK_D];
   logic [DW-1:0]    r_depth;
   logic [3:0]       r_id;
   logic [PC_W-1:0]  r_vec, r_ret_pc;
   logic             r_ret_valid;
   logic [15:0]      r_rdata;

   logic             w_wr_ctrl, w_wr_en, w_wr_pend, w_wr_mode, w_wr_force;
   logic [N_SRC-1:0] w_wbits, w_elig, w_allow, w_cand_any, w_cand;
   logic [N_SRC-1:0] w_set, w_clr, w_pend_next, w_id_onehot, w_active_low;
   logic             w_full, w_empty, w_has, w_id_elig;
   logic [3:0]       w_win;
   logic [31:0]      w_vec_full;
   logic [PC_W-1:0]  w_top;
   logic             w_latch, w_push, w_pop, w_err_set, w_ovf_set;
   logic             w_unused;

   assign w_wr_ctrl  = reg_we && (reg_addr == 3'd0);
   assign w_wr_en    = reg_we && (reg_addr == 3'd1);
   assign w_wr_pend  = reg_we && (reg_addr == 3'd2);
   assign w_wr_mode  = reg_we && (reg_addr == 3'd3);
   assign w_wr_force = reg_we && (reg_addr == 3'd6);
   assign w_wbits    = reg_wdata[N_SRC-1:0];

   assign w_elig       = r_pend & r_en & {N_SRC{r_ge}};
   assign w_cand_any   = w_elig & w_allow;
   assign w_full       = (r_depth == DW'(STACK_D));
   assign w_empty      = (r_depth == '0);
   assign w_cand       = w_full ? '0 : w_cand_any;
   assign w_active_low = r_active & (~r_active + 1'b1);

   // Per source: nesting mask, pending next-state (a new edge beats any clear) and id decode.
   generate
      for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
         assign w_allow[gi]     = ~|r_active | (r_ne & ~|r_active[gi:0]);
         assign w_set[gi]       = (r_sync2[gi] & ~r_sync_d[gi]) | (w_wr_force & w_wbits[gi]);
         assign w_clr[gi]       = (w_wr_pend & w_wbits[gi]) | (w_push & w_id_onehot[gi]);
         assign w_pend_next[gi] = r_mode[gi] ? (w_set[gi] | (r_pend[gi] & ~w_clr[gi]))
                                             : r_sync2[gi];
         assign w_id_onehot[gi] = (r_id == 4'(gi));
      end
   endgenerate

   always_comb begin
      w_win     = '0;
      w_has     = 1'b0;
      w_id_elig = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_cand[i]) begin
            w_win = 4'(i);
            w_has = 1'b1;
         end
         if (r_id == 4'(i)) w_id_elig = w_elig[i];
      end
      w_vec_full = 32'(VEC_BASE) + 32'(w_win) * 32'(VEC_STRIDE);
   end

   always_comb begin
      w_top = '0;
      for (int i = 0; i < STACK_D; i++)
         if (r_depth == DW'(i + 1)) w_top = r_stack[i];
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_latch      = 1'b0;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_err_set    = 1'b0;
      w_ovf_set    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_has) begin
               w_latch      = 1'b1;
               w_state_next = S_REQ;
            end else if (w_full && (|w_cand_any)) begin
               w_ovf_set = 1'b1;
            end
            if (irq_ack) w_err_set = 1'b1;
            if (reti) begin
               if (w_empty) w_err_set = 1'b1;
               else         w_pop     = 1'b1;
            end
         end
         S_REQ: begin
            if (irq_ack) begin
               w_push       = 1'b1;
               w_state_next = S_IDLE;
               if (reti) w_err_set = 1'b1;
            end else begin
               if (!w_id_elig) w_state_next = S_IDLE;
               if (reti) begin
                  if (w_empty) w_err_set = 1'b1;
                  else         w_pop     = 1'b1;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_sync_d    <= '0;
         r_pend      <= '0;
         r_en        <= '0;
         r_mode      <= '0;
         r_active    <= '0;
         r_ge        <= 1'b0;
         r_ne        <= 1'b0;
         r_err       <= 1'b0;
         r_ovf       <= 1'b0;
         r_depth     <= '0;
         r_id        <= '0;
         r_vec       <= '0;
         r_ret_pc    <= '0;
         r_ret_valid <= 1'b0;
         r_rdata     <= '0;
         for (int i = 0; i < STACK_D; i++) r_stack[i] <= '0;
      end else begin
         r_sync1  <= irq_src;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
         r_pend   <= w_pend_next;
         if (w_wr_ctrl) begin
            r_ge <= reg_wdata[15];
            r_ne <= reg_wdata[8];
         end
         r_err <= w_err_set | (r_err & ~(w_wr_ctrl & reg_wdata[1]));
         r_ovf <= w_ovf_set | (r_ovf & ~(w_wr_ctrl & reg_wdata[0]));
         if (w_wr_en)   r_en   <= w_wbits;
         if (w_wr_mode) r_mode <= w_wbits;
         r_active <= (r_active | (w_push ? w_id_onehot : '0)) & ~(w_pop ? w_active_low : '0);
         if (w_latch) begin
            r_id  <= w_win;
            r_vec <= w_vec_full[PC_W-1:0];
         end
         for (int i = 0; i < STACK_D; i++)
            if (w_push && (r_depth == DW'(i))) r_stack[i] <= pc_in;
         if (w_push)     r_depth <= r_depth + 1'b1;
         else if (w_pop) r_depth <= r_depth - 1'b1;
         r_ret_valid <= w_pop;
         if (w_pop) r_ret_pc <= w_top;
         case (reg_addr)
            3'd0:    r_rdata <= {r_ge, 6'b0, r_ne, 6'b0, r_err, r_ovf};
            3'd1:    r_rdata <= 16'(r_en);
            3'd2:    r_rdata <= 16'(r_pend);
            3'd3:    r_rdata <= 16'(r_mode);
            3'd4:    r_rdata <= 16'(r_active);
            3'd5:    r_rdata <= 16'(w_top);
            3'd7:    r_rdata <= 16'(r_depth);
            default: r_rdata <= '0;
         endcase
      end
   end

   assign irq_req   = (r_state == S_REQ);
   assign irq_vec   = r_vec;
   assign irq_id    = r_id;
   assign ret_pc    = r_ret_pc;
   assign ret_valid = r_ret_valid;
   assign reg_rdata = r_rdata;
   assign w_unused  = &{1'b0, reg_wdata, w_vec_full};
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: a STACK_D=4 unit plus a STACK_D=2 unit on shared stimulus
// for the stack-overflow case.
module tb_intr_ctrl;
   localparam logic [2:0] A_CTRL = 3'd0, A_EN = 3'd1, A_PEND = 3'd2, A_MODE = 3'd3;
   localparam logic [2:0] A_ACT  = 3'd4, A_SPC = 3'd5, A_FORCE = 3'd6, A_DEPTH = 3'd7;

   logic        clk, rst, reg_we, irq_ack, reti;
   logic [7:0]  irq_src, pc_in;
   logic [2:0]  reg_addr;
   logic [15:0] reg_wdata, reg_rdata, reg_rdata2;
   logic        irq_req, irq_req2, ret_valid, ret_valid2;
   logic [7:0]  irq_vec, irq_vec2, ret_pc, ret_pc2;
   logic [3:0]  irq_id, irq_id2;
   int          checks = 0;
   int          errors = 0;

   intr_ctrl u_dut (
      .clk(clk), .rst(rst), .irq_src(irq_src), .reg_we(reg_we), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq_req(irq_req), .irq_vec(irq_vec),
      .irq_id(irq_id), .irq_ack(irq_ack), .pc_in(pc_in), .reti(reti), .ret_pc(ret_pc),
      .ret_valid(ret_valid)
   );

   intr_ctrl #(.STACK_D(2)) u_dut2 (
      .clk(clk), .rst(rst), .irq_src(irq_src), .reg_we(reg_we), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata2), .irq_req(irq_req2), .irq_vec(irq_vec2),
      .irq_id(irq_id2), .irq_ack(irq_ack), .pc_in(pc_in), .reti(reti), .ret_pc(ret_pc2),
      .ret_valid(ret_valid2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      reg_we = 1'b1; reg_addr = a; reg_wdata = d;
      tick();
      reg_we = 1'b0;
      $display("write addr=%0d data=0x%04h", a, d);
   endtask

   task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
      reg_addr = a;
      tick();
      chk(tag, 32'(reg_rdata), 32'(exp));
      $display("read  addr=%0d data=0x%04h", a, reg_rdata);
   endtask

   task automatic ack(input logic [7:0] pc);
      pc_in = pc; irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      $display("ack   pc=0x%02h", pc);
   endtask

   task automatic do_reti();
      reti = 1'b1;
      tick();
      reti = 1'b0;
      $display("reti  ret_valid=%0b ret_pc=0x%02h", ret_valid, ret_pc);
   endtask

   task automatic chk_req(input string tag, input logic [7:0] vec, input logic [3:0] id);
      chk({tag, "_req"}, 32'(irq_req), 32'd1);
      chk({tag, "_vec"}, 32'(irq_vec), 32'(vec));
      chk({tag, "_id"},  32'(irq_id),  32'(id));
   endtask

   initial begin
      rst = 1'b1; irq_src = '0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
      irq_ack = 1'b0; pc_in = '0; reti = 1'b0;
      repeat (3) tick();
      chk("rst_req", 32'(irq_req), 0);
      chk("rst_vec", 32'(irq_vec), 0);
      chk("rst_rdata", 32'(reg_rdata), 0);
      rst = 1'b0;

      // Edge latency and vector of source 0
      wr(A_EN, 16'h0001); wr(A_MODE, 16'h0001); wr(A_CTRL, 16'h8000);
      irq_src = 8'h01;
      repeat (3) tick();
      chk("lat_k3_req", 32'(irq_req), 0);
      tick();
      chk_req("lat_k4", 8'd16, 4'd0);
      ack(8'h05);
      irq_src = 8'h00;
      chk("ack_req_low", 32'(irq_req), 0);
      rd("t1_depth", A_DEPTH, 16'h0001);
      rd("t1_spc", A_SPC, 16'h0005);
      rd("t1_active", A_ACT, 16'h0001);
      rd("t1_pend", A_PEND, 16'h0000);
      do_reti();
      chk("t1_ret_valid", 32'(ret_valid), 1);
      chk("t1_ret_pc", 32'(ret_pc), 32'h05);
      tick();
      chk("t1_ret_valid_pulse", 32'(ret_valid), 0);
      rd("t1_depth0", A_DEPTH, 16'h0000);

      // Priority, non-retargeting, then nesting with NE
      wr(A_EN, 16'h00FF); wr(A_MODE, 16'h00FF);
      irq_src = 8'h28;
      repeat (4) tick();
      chk_req("prio3", 8'd64, 4'd3);
      irq_src = 8'h2A;
      repeat (4) tick();
      chk_req("noretarget", 8'd64, 4'd3);
      wr(A_CTRL, 16'h8100);
      ack(8'h33);
      tick();
      chk_req("nest1", 8'd32, 4'd1);
      irq_src = 8'h20;
      ack(8'h11);
      tick();
      chk("nest1_idle", 32'(irq_req), 0);
      do_reti();
      chk("t2_ret_a", 32'(ret_pc), 32'h11);
      tick();
      rd("t2_active", A_ACT, 16'h0008);
      do_reti();
      chk("t2_ret_b", 32'(ret_pc), 32'h33);
      tick();
      chk_req("src5", 8'h60, 4'd5);

      // Three-deep nesting; the STACK_D=2 unit must hold off the third request
      ack(8'h10);
      irq_src = 8'h28;
      repeat (4) tick();
      chk_req("n_src3", 8'd64, 4'd3);
      ack(8'h40);
      irq_src = 8'h2A;
      repeat (4) tick();
      chk_req("n_src1", 8'd32, 4'd1);
      chk("ovf_req_held", 32'(irq_req2), 0);
      reg_addr = A_CTRL;
      tick();
      chk("ctrl_no_ovf", 32'(reg_rdata), 32'h8100);
      chk("ctrl_ovf", 32'(reg_rdata2), 32'h8101);
      ack(8'h42);
      rd("n_depth3", A_DEPTH, 16'h0003);
      do_reti();
      chk("n_ret_42", 32'(ret_pc), 32'h42);
      chk("ovf_pop_pc", 32'(ret_pc2), 32'h40);
      rd("n_active_a", A_ACT, 16'h0028);
      chk("ovf_rereq", 32'(irq_req2), 1);
      chk("ovf_rereq_vec", 32'(irq_vec2), 32);
      do_reti();
      chk("n_ret_40", 32'(ret_pc), 32'h40);
      rd("n_active_b", A_ACT, 16'h0020);
      do_reti();
      chk("n_ret_10", 32'(ret_pc), 32'h10);
      rd("n_active_c", A_ACT, 16'h0000);
      rd("n_depth0", A_DEPTH, 16'h0000);

      // Error conditions and FORCE
      rd("err_clean", A_CTRL, 16'h8100);
      do_reti();
      chk("reti_empty_valid", 32'(ret_valid), 0);
      rd("reti_empty_err", A_CTRL, 16'h8102);
      wr(A_CTRL, 16'h8102);
      rd("err_w1c", A_CTRL, 16'h8100);
      ack(8'h99);
      rd("ack_idle_err", A_CTRL, 16'h8102);
      rd("ack_idle_depth", A_DEPTH, 16'h0000);
      wr(A_CTRL, 16'h8102);
      wr(A_FORCE, 16'h0004);
      tick();
      chk_req("force2", 8'd48, 4'd2);
      pc_in = 8'h77; irq_ack = 1'b1; reti = 1'b1;
      tick();
      irq_ack = 1'b0; reti = 1'b0;
      chk("ackreti_no_ret", 32'(ret_valid), 0);
      rd("ackreti_err", A_CTRL, 16'h8102);
      rd("ackreti_spc", A_SPC, 16'h0077);
      rd("ackreti_active", A_ACT, 16'h0004);
      do_reti();
      chk("ackreti_pop", 32'(ret_pc), 32'h77);

      // Level mode and withdrawal
      rst = 1'b1; irq_src = '0;
      repeat (2) tick();
      rst = 1'b0;
      wr(A_EN, 16'h0080); wr(A_CTRL, 16'h8000);
      irq_src = 8'h80;
      repeat (4) tick();
      chk_req("lvl", 8'h80, 4'd7);
      ack(8'h21);
      chk("lvl_ack_low", 32'(irq_req), 0);
      tick();
      chk("lvl_blocked", 32'(irq_req), 0);
      do_reti();
      chk("lvl_ret", 32'(ret_pc), 32'h21);
      tick();
      chk_req("lvl_rereq", 8'h80, 4'd7);
      wr(A_EN, 16'h0000);
      tick();
      chk("withdraw_req", 32'(irq_req), 0);
      rd("withdraw_depth", A_DEPTH, 16'h0000);
      rd("pend_disabled", A_PEND, 16'h0080);

      // Reset in the middle of a request with two entries stacked
      irq_src = '0;
      wr(A_MODE, 16'h000F); wr(A_EN, 16'h000F); wr(A_CTRL, 16'h8100);
      wr(A_FORCE, 16'h0008);
      tick();
      chk_req("r_src3", 8'd64, 4'd3);
      ack(8'h30);
      wr(A_FORCE, 16'h0002);
      tick();
      chk_req("r_src1", 8'd32, 4'd1);
      ack(8'h31);
      wr(A_FORCE, 16'h0001);
      tick();
      chk_req("r_src0", 8'd16, 4'd0);
      rd("r_depth2", A_DEPTH, 16'h0002);
      rst = 1'b1;
      tick();
      chk("mid_rst_req", 32'(irq_req), 0);
      chk("mid_rst_vec", 32'(irq_vec), 0);
      chk("mid_rst_id", 32'(irq_id), 0);
      chk("mid_rst_ret_pc", 32'(ret_pc), 0);
      chk("mid_rst_ret_valid", 32'(ret_valid), 0);
      chk("mid_rst_rdata", 32'(reg_rdata), 0);
      rst = 1'b0;
      for (int a = 0; a < 8; a++) rd("mid_rst_reg", 3'(a), 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
